alu_issue_arbiter: RTL

Shares the two ALU execution slots (E0/E1) between NREQ issue requesters: ALU buffer slot 0, ALU buffer slot 1, and the branch/address buffer. Each cycle it grants up to two ready instructions in round-robin order and registers them into the slot outputs with their instruction numbers. It tracks per-slot occupancy so multi-cycle mult/div ops block their slot. It sits between the reservation buffers and the ALU/ROB issue path.

---
 rtl/alu_issue_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
// Shares the two ALU execution slots (E0/E1) between NREQ issue requesters.
// Each cycle up to two ready requesters are granted in round-robin order.
// The granted instructions are registered onto the slot outputs one cycle
// later. A long mult/div op keeps its slot occupied for LONG_LAT cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  per-requester ready instruction
//   req_instr  per-requester instruction, slice [i*DW +: DW]
//   req_no     per-requester instruction number, slice [i*DW +: DW]
//   req_ready  combinational grant per requester
//   eu_stall   slot u cannot accept a new instruction this cycle
//   eu_valid   registered one-cycle issue strobe per slot
//   eu_instr   issued instruction per slot, held until the next issue
//   eu_no      issued instruction number per slot, held
//   slot_busy  slot u is occupied by a multi-cycle op
//   issue_cnt  running count of issued instructions, wraps
module alu_issue_arbiter #(
    parameter int NREQ     = 3,
    parameter int DW       = 32,
    parameter int LONG_LAT = 4,
    parameter int CW       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_instr,
    input  logic [NREQ*DW-1:0]   req_no,
    output logic [NREQ-1:0]      req_ready,
    input  logic [1:0]           eu_stall,
    output logic [1:0]           eu_valid,
    output logic [2*DW-1:0]      eu_instr,
    output logic [2*DW-1:0]      eu_no,
    output logic [1:0]           slot_busy,
    output logic [CW-1:0]        issue_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;
    // With LONG_LAT=1 this is zero, so long ops naturally act single-cycle.
    localparam logic [BW-1:0] LONG_LOAD = BW'(LONG_LAT - 1);

    logic [1:0]             r_eu_valid;
    logic [1:0][DW-1:0]     r_eu_instr;
    logic [1:0][DW-1:0]     r_eu_no;
    logic [1:0][BW-1:0]     r_busy_cnt;
    logic [PW-1:0]          r_rr_ptr;
    logic [CW-1:0]          r_issue_cnt;

    logic [1:0]             w_free;
    logic [1:0]             w_gnt;
    logic [1:0][PW-1:0]     w_gnt_idx;
    logic [NREQ-1:0]        w_ready;
    logic [PW-1:0]          w_rr_next;
    logic [1:0][DW-1:0]     w_sel_instr;
    logic [1:0][DW-1:0]     w_sel_no;

    // mult/multu/div/divu: SPECIAL opcode with funct 0110xx
    function automatic logic is_long(input logic [DW-1:0] ins);
        return (ins[31:26] == 6'b000000) && (ins[5:2] == 4'b0110);
    endfunction

    assign w_free[0] = (r_busy_cnt[0] == '0) && !eu_stall[0];
    assign w_free[1] = (r_busy_cnt[1] == '0) && !eu_stall[1];

    // Greedy scan from rr_ptr: the first valid requester takes the lowest
    // free slot, the next one takes whatever slot remains.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_ready   = '0;
        w_rr_next = r_rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            logic [PW:0]   v_sum;
            logic [PW:0]   v_nxt;
            logic [PW-1:0] v_idx;
            v_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
            if (v_sum >= (PW+1)'(NREQ)) begin
                v_sum = v_sum - (PW+1)'(NREQ);
            end
            v_idx = v_sum[PW-1:0];
            v_nxt = v_sum + (PW+1)'(1);
            if (v_nxt >= (PW+1)'(NREQ)) begin
                v_nxt = '0;
            end
            if (rst && req_valid[v_idx]) begin
                if (w_free[0] && !w_gnt[0]) begin
                    w_gnt[0]       = 1'b1;
                    w_gnt_idx[0]   = v_idx;
                    w_ready[v_idx] = 1'b1;
                    w_rr_next      = v_nxt[PW-1:0];
                end else if (w_free[1] && !w_gnt[1]) begin
                    w_gnt[1]       = 1'b1;
                    w_gnt_idx[1]   = v_idx;
                    w_ready[v_idx] = 1'b1;
                    w_rr_next      = v_nxt[PW-1:0];
                end
            end
        end
    end

    always_comb begin
        for (int u = 0; u < 2; u++) begin
            w_sel_instr[u] = req_instr[int'(w_gnt_idx[u])*DW +: DW];
            w_sel_no[u]    = req_no[int'(w_gnt_idx[u])*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_eu_valid  <= '0;
            r_eu_instr  <= '0;
            r_eu_no     <= '0;
            r_busy_cnt  <= '0;
            r_rr_ptr    <= '0;
            r_issue_cnt <= '0;
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (w_gnt[u]) begin
                    r_eu_valid[u] <= 1'b1;
                    r_eu_instr[u] <= w_sel_instr[u];
                    r_eu_no[u]    <= w_sel_no[u];
                    r_busy_cnt[u] <= is_long(w_sel_instr[u]) ? LONG_LOAD : '0;
                end else begin
                    r_eu_valid[u] <= 1'b0;
                    // Occupancy drains even while the slot is stalled.
                    if (r_busy_cnt[u] != '0) begin
                        r_busy_cnt[u] <= r_busy_cnt[u] - BW'(1);
                    end
                end
            end
            r_rr_ptr    <= w_rr_next;
            r_issue_cnt <= r_issue_cnt + CW'(w_gnt[0]) + CW'(w_gnt[1]);
        end
    end

    assign req_ready = w_ready;
    assign eu_valid  = r_eu_valid;
    assign eu_instr  = r_eu_instr;
    assign eu_no     = r_eu_no;
    assign slot_busy = {(r_busy_cnt[1] != '0), (r_busy_cnt[0] != '0)};
    assign issue_cnt = r_issue_cnt;

endmodule
